matmul_tile_scheduler: RTL and testbench
========================================

# matmul_tile_scheduler

Sequences one full matrix multiplication job into a stream of 8×8 output-tile descriptors (`matrix_mul_ctrl_t`) for the MAC-array controller. It walks tile rows and columns, generates A, B and C BRAM start addresses incrementally without multipliers, and issues each descriptor on a valid/ready handshake. It counts the controller's output writes and signals job completion after the last tile's final row is written. It sits between the host/DMA job register and the matrix multiply controller.

## Interface
- `TILE`, 8: tile edge; equals MAC array width.
- `MAX_TILES_W`, 8: width of the tile-count fields.
- `WE_CNT_W`, 20: width of the output-write counter; must be ≥ log2(TILE·255·255).
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high; clock `clk`.
- `job_valid`  in  1  job present.
- `job_ready`  out  1  scheduler can accept a job; high only in IDLE.
- `job`  in  `matmul_job_t`  fields:
  - `a_base`[14:0], `b_base`[16:0], `c_base`[14:0]: start addresses.
  - `a_line`[14:0], `b_line`[16:0], `c_line`[14:0]: line sizes.
  - `m_tiles`[7:0], `n_tiles`[7:0]: tile counts.
  - `k`[11:0]: inner dimension.
- `desc`  out  `matrix_mul_ctrl_t`  tile descriptor; `desc.valid` is the handshake valid.
- `desc_ready`  in  1  controller accepts; driven from the controller's `req_valid`.
- `output_we`  in  1  monitored write strobe from the controller.
- `busy`  out  1  job in progress (any state other than IDLE).
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - `job_ready`=1.
  - On `job_valid`, latch the job, set `i`=`j`=0, initialise the address accumulators, clear `we_cnt`, and go to ISSUE.
  - If `m_tiles`==0, `n_tiles`==0 or `k`==0: go to DRAIN with target 0 instead; `done` fires the next cycle and no descriptors are issued.
- ISSUE: drive `desc.valid`=1 with the current tile (`i`,`j`):
  - `input_a_addr_begin` = `a_base` + `i`.
  - `input_b_addr_begin` = `b_base` + `j`.
  - `output_c_addr_begin` = `c_row` + `j`, where `c_row` = `c_base` + `i`·TILE·`c_line`, accumulated by adding `c_line`<<3 on each `i` step.
  - Line sizes are copied from the job; `matrix_n` = `k`.
- Handshake and walk order:
  - A transfer occurs on `desc.valid & desc_ready`.
  - `j` is the inner loop: after a transfer `j`++; when `j`==`n_tiles`−1, `j`←0 and `i`++.
  - The transfer of tile (`m_tiles`−1, `n_tiles`−1) moves to DRAIN.
- Descriptor fields are held stable while `valid & !ready`.
- `we_cnt` increments on every `output_we` in ISSUE or DRAIN. Target = TILE·`m_tiles`·`n_tiles`, computed at job latch by a shift-add over 8 cycles, which completes before the first write can arrive.
- DRAIN: when `we_cnt`==target, pulse `done` and return to IDLE.
- `output_we` in IDLE is ignored.
- All address arithmetic is modulo the field width; wrap is silent.

## Timing
- Reset values:
  - FSM=IDLE, `job_ready`=1, `busy`=0, `done`=0, `desc`='0, `we_cnt`=0.
- Reset mid-job aborts immediately: no `done` is generated and the next cycle is IDLE.
- Job accepted at cycle T → `desc.valid`=1 at T+1.
- With `desc_ready` held high, descriptors transfer back-to-back, one per cycle.
- After the last transfer, `desc.valid`=0 on the following cycle.
- Final counted `output_we` at cycle W → `done`=1 at W+1 and `job_ready`=1 at W+1.
- A zero-size job accepted at T → `done` at T+2.
- `output_we` coinciding with the final descriptor transfer is counted.

## Structure
- Shared package `matmul_pkg`:
  - `matrix_mul_ctrl_t`, `matmul_job_t`.
  - Address typedefs `feature_bram_addr_t`, `weight_bram_addr_t`, `output_bram_addr_t`.
  - Constant `MATMUL_TILE`=8.
- Sub-module `matmul_tile_addr_gen`: holds the `i`/`j` counters and the A/B/C accumulators. It advances on `step` and flags `last`.

## Test plan
- Job m=1, n=1, k=16, bases 0x10/0x20/0x30, `c_line`=2, `desc_ready`=1 → one descriptor with a=0x10, b=0x20, c=0x30, n=16. After 8 `output_we`, `done` fires on the cycle after the 8th.
- m=2, n=3, `c_line`=4, `c_base`=0 → six descriptors.
  - c order: 0, 1, 2, 32, 33, 34.
  - a order: 0, 0, 0, 1, 1, 1.
  - b order: 0, 1, 2, 0, 1, 2.
- Stall on the same job: `desc_ready` low 5 cycles on the 2nd descriptor → fields unchanged during the stall, no skipped or duplicated tile.
- m=0 → no `desc.valid`; `done` at T+2.
- `rst` asserted during DRAIN after 3 of 8 writes → `done` never pulses, `busy`=0. A new job is then accepted and `we_cnt` restarts from 0.
- `a_base`=0x7FFF, m=2 → second tile row a address wraps to 0x0000.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix multiply tile scheduler and the
// MAC-array controller it feeds.
package matmul_pkg;

    localparam int MATMUL_TILE = 8;

    typedef logic [14:0] feature_bram_addr_t;
    typedef logic [16:0] weight_bram_addr_t;
    typedef logic [14:0] output_bram_addr_t;

    // One full multiplication job as written by the host/DMA job register.
    typedef struct packed {
        feature_bram_addr_t a_base;
        weight_bram_addr_t  b_base;
        output_bram_addr_t  c_base;
        feature_bram_addr_t a_line;
        weight_bram_addr_t  b_line;
        output_bram_addr_t  c_line;
        logic [7:0]         m_tiles;
        logic [7:0]         n_tiles;
        logic [11:0]        k;
    } matmul_job_t;

    // Descriptor for one 8x8 output tile; valid doubles as the handshake valid.
    typedef struct packed {
        logic               valid;
        feature_bram_addr_t input_a_addr_begin;
        weight_bram_addr_t  input_b_addr_begin;
        output_bram_addr_t  output_c_addr_begin;
        feature_bram_addr_t input_a_line_size;
        weight_bram_addr_t  input_b_line_size;
        output_bram_addr_t  output_c_line_size;
        logic [11:0]        matrix_n;
    } matrix_mul_ctrl_t;

    // A job with any zero dimension produces no tiles at all.
    function automatic logic job_is_empty(input matmul_job_t j);
        return (j.m_tiles == 8'd0) || (j.n_tiles == 8'd0) || (j.k == 12'd0);
    endfunction

endpackage

// File: rtl/matmul_tile_addr_gen.sv
// Tile walker: keeps the (i, j) tile position and the A/B/C start-address
// accumulators. Addresses advance by additions only; j is the inner loop.
module matmul_tile_addr_gen
    import matmul_pkg::*;
#(
    parameter int TILE        = MATMUL_TILE,
    parameter int MAX_TILES_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   step_i,
    input  feature_bram_addr_t     a_base_i,
    input  weight_bram_addr_t      b_base_i,
    input  output_bram_addr_t      c_base_i,
    input  output_bram_addr_t      c_line_i,
    input  logic [MAX_TILES_W-1:0] m_tiles_i,
    input  logic [MAX_TILES_W-1:0] n_tiles_i,
    output feature_bram_addr_t     a_addr_o,
    output weight_bram_addr_t      b_addr_o,
    output output_bram_addr_t      c_addr_o,
    output logic                   last_o
);

    localparam int TILE_SHIFT = $clog2(TILE);
    localparam logic [MAX_TILES_W-1:0] TILE_ONE = 1;

    logic [MAX_TILES_W-1:0] i_q, i_d;
    logic [MAX_TILES_W-1:0] j_q, j_d;
    logic [MAX_TILES_W-1:0] m_tiles_q, m_tiles_d;
    logic [MAX_TILES_W-1:0] n_tiles_q, n_tiles_d;
    feature_bram_addr_t     a_q, a_d;
    weight_bram_addr_t      b_q, b_d;
    weight_bram_addr_t      b_base_q, b_base_d;
    output_bram_addr_t      c_row_q, c_row_d;
    output_bram_addr_t      c_q, c_d;
    output_bram_addr_t      c_line_q, c_line_d;
    output_bram_addr_t      c_step;
    logic                   row_end;

    assign c_step  = c_line_q << TILE_SHIFT;
    assign row_end = (j_q == (n_tiles_q - TILE_ONE));

    // Next tile position and addresses: reload on a new job, advance on a transfer.
    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        m_tiles_d = m_tiles_q;
        n_tiles_d = n_tiles_q;
        a_d       = a_q;
        b_d       = b_q;
        b_base_d  = b_base_q;
        c_row_d   = c_row_q;
        c_d       = c_q;
        c_line_d  = c_line_q;
        if (load_i) begin
            i_d       = '0;
            j_d       = '0;
            m_tiles_d = m_tiles_i;
            n_tiles_d = n_tiles_i;
            a_d       = a_base_i;
            b_d       = b_base_i;
            b_base_d  = b_base_i;
            c_row_d   = c_base_i;
            c_d       = c_base_i;
            c_line_d  = c_line_i;
        end else if (step_i) begin
            if (row_end) begin
                j_d     = '0;
                i_d     = i_q + TILE_ONE;
                a_d     = a_q + feature_bram_addr_t'(1);
                b_d     = b_base_q;
                c_row_d = c_row_q + c_step;
                c_d     = c_row_q + c_step;
            end else begin
                j_d = j_q + TILE_ONE;
                b_d = b_q + weight_bram_addr_t'(1);
                c_d = c_q + output_bram_addr_t'(1);
            end
        end
    end

    // Walker state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q       <= '0;
            j_q       <= '0;
            m_tiles_q <= '0;
            n_tiles_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            b_base_q  <= '0;
            c_row_q   <= '0;
            c_q       <= '0;
            c_line_q  <= '0;
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            m_tiles_q <= m_tiles_d;
            n_tiles_q <= n_tiles_d;
            a_q       <= a_d;
            b_q       <= b_d;
            b_base_q  <= b_base_d;
            c_row_q   <= c_row_d;
            c_q       <= c_d;
            c_line_q  <= c_line_d;
        end
    end

    assign a_addr_o = a_q;
    assign b_addr_o = b_q;
    assign c_addr_o = c_q;
    assign last_o   = row_end && (i_q == (m_tiles_q - TILE_ONE));

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Turns one matrix multiplication job into a stream of 8x8 output-tile
// descriptors, then waits for the controller's output writes to finish
// before signalling completion.
module matmul_tile_scheduler
    import matmul_pkg::*;
#(
    parameter int TILE        = MATMUL_TILE,
    parameter int MAX_TILES_W = 8,
    parameter int WE_CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  matmul_job_t      job,
    output matrix_mul_ctrl_t desc,
    input  logic             desc_ready,
    input  logic             output_we,
    output logic             busy,
    output logic             done
);

    localparam int TILE_SHIFT = $clog2(TILE);
    localparam int PROD_W     = 2 * MAX_TILES_W;
    localparam int CNT_W      = $clog2(MAX_TILES_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   done_q, done_d;

    feature_bram_addr_t a_line_q, a_line_d;
    weight_bram_addr_t  b_line_q, b_line_d;
    output_bram_addr_t  c_line_q, c_line_d;
    logic [11:0]        k_q, k_d;

    logic [PROD_W-1:0]      mul_acc_q, mul_acc_d;
    logic [PROD_W-1:0]      mul_mcand_q, mul_mcand_d;
    logic [MAX_TILES_W-1:0] mul_mplier_q, mul_mplier_d;
    logic [CNT_W-1:0]       mul_cnt_q, mul_cnt_d;
    logic                   mul_done;

    logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;
    logic [WE_CNT_W-1:0] target;
    logic                we_match;

    logic               accept;
    logic               empty_job;
    logic               step;
    logic               last_tile;
    feature_bram_addr_t a_addr;
    weight_bram_addr_t  b_addr;
    output_bram_addr_t  c_addr;

    assign empty_job = job_is_empty(job);
    assign accept    = (state_q == ST_IDLE) && job_valid;
    assign step      = (state_q == ST_ISSUE) && desc_ready;
    assign mul_done  = (mul_cnt_q == '0);
    assign target    = WE_CNT_W'(mul_acc_q) << TILE_SHIFT;
    assign we_match  = mul_done && (we_cnt_d == target);

    matmul_tile_addr_gen #(
        .TILE        (TILE),
        .MAX_TILES_W (MAX_TILES_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .step_i    (step),
        .a_base_i  (job.a_base),
        .b_base_i  (job.b_base),
        .c_base_i  (job.c_base),
        .c_line_i  (job.c_line),
        .m_tiles_i (MAX_TILES_W'(job.m_tiles)),
        .n_tiles_i (MAX_TILES_W'(job.n_tiles)),
        .a_addr_o  (a_addr),
        .b_addr_o  (b_addr),
        .c_addr_o  (c_addr),
        .last_o    (last_tile)
    );

    // Tile-count product m*n by shift-and-add, one multiplier bit per cycle.
    always_comb begin
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
        if (accept) begin
            mul_acc_d    = '0;
            mul_mcand_d  = PROD_W'(job.m_tiles);
            mul_mplier_d = empty_job ? '0 : MAX_TILES_W'(job.n_tiles);
            mul_cnt_d    = empty_job ? '0 : CNT_W'(MAX_TILES_W);
        end else if (!mul_done) begin
            if (mul_mplier_q[0]) begin
                mul_acc_d = mul_acc_q + mul_mcand_q;
            end
            mul_mcand_d  = mul_mcand_q << 1;
            mul_mplier_d = mul_mplier_q >> 1;
            mul_cnt_d    = mul_cnt_q - CNT_W'(1);
        end
    end

    // Output-write counter: cleared per job, counts only while a job is active.
    always_comb begin
        we_cnt_d = we_cnt_q;
        if (accept) begin
            we_cnt_d = '0;
        end else if ((state_q != ST_IDLE) && output_we) begin
            we_cnt_d = we_cnt_q + WE_CNT_W'(1);
        end
    end

    // Job fields the descriptor needs beyond the walker's addresses.
    always_comb begin
        a_line_d = a_line_q;
        b_line_d = b_line_q;
        c_line_d = c_line_q;
        k_d      = k_q;
        if (accept) begin
            a_line_d = job.a_line;
            b_line_d = job.b_line;
            c_line_d = job.c_line;
            k_d      = job.k;
        end
    end

    // Scheduler FSM: accept, issue tiles in order, then wait for the last write.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        job_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    state_d = empty_job ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (desc_ready && last_tile) begin
                    if (we_match) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (we_match) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Descriptor is driven only while issuing; it reads as all-zero otherwise.
    always_comb begin
        desc = '0;
        if (state_q == ST_ISSUE) begin
            desc.valid               = 1'b1;
            desc.input_a_addr_begin  = a_addr;
            desc.input_b_addr_begin  = b_addr;
            desc.output_c_addr_begin = c_addr;
            desc.input_a_line_size   = a_line_q;
            desc.input_b_line_size   = b_line_q;
            desc.output_c_line_size  = c_line_q;
            desc.matrix_n            = k_q;
        end
    end

    // State, counters and latched job fields; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            done_q       <= 1'b0;
            a_line_q     <= '0;
            b_line_q     <= '0;
            c_line_q     <= '0;
            k_q          <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
            we_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            a_line_q     <= a_line_d;
            b_line_q     <= b_line_d;
            c_line_q     <= c_line_d;
            k_q          <= k_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
            we_cnt_q     <= we_cnt_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler: a table of expected tile
// descriptors walked in loops, plus hand-written reset/stall/zero-job sequences.
module tb_matmul_tile_scheduler;
    import matmul_pkg::*;

    typedef struct {
        feature_bram_addr_t a;
        weight_bram_addr_t  b;
        output_bram_addr_t  c;
        logic [11:0]        n;
    } tileExp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    matmul_job_t      job;
    matrix_mul_ctrl_t desc;
    logic             desc_ready;
    logic             output_we;
    logic             busy;
    logic             done;

    int vecCount  = 0;
    int missCount = 0;

    tileExp_t expTab [10];

    matmul_tile_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job        (job),
        .desc       (desc),
        .desc_ready (desc_ready),
        .output_we  (output_we),
        .busy       (busy),
        .done       (done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever loses its way.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a job for one cycle starting at a negedge; returns at the negedge after acceptance.
    task automatic applyStimulus(input feature_bram_addr_t aBase, input weight_bram_addr_t bBase,
                                 input output_bram_addr_t cBase, input output_bram_addr_t cLine,
                                 input logic [7:0] m, input logic [7:0] n, input logic [11:0] k);
        job.a_base  = aBase;
        job.b_base  = bBase;
        job.c_base  = cBase;
        job.a_line  = 15'h4;
        job.b_line  = 17'h5;
        job.c_line  = cLine;
        job.m_tiles = m;
        job.n_tiles = n;
        job.k       = k;
        job_valid   = 1'b1;
        checkOutput("jobReadyIdle", {31'd0, job_ready}, 32'd1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic checkTile(input int idx);
        checkOutput($sformatf("tile%0d.valid", idx), {31'd0, desc.valid}, 32'd1);
        checkOutput($sformatf("tile%0d.a", idx), {17'd0, desc.input_a_addr_begin}, {17'd0, expTab[idx].a});
        checkOutput($sformatf("tile%0d.b", idx), {15'd0, desc.input_b_addr_begin}, {15'd0, expTab[idx].b});
        checkOutput($sformatf("tile%0d.c", idx), {17'd0, desc.output_c_addr_begin}, {17'd0, expTab[idx].c});
        checkOutput($sformatf("tile%0d.n", idx), {20'd0, desc.matrix_n}, {20'd0, expTab[idx].n});
        checkOutput($sformatf("tile%0d.aLine", idx), {17'd0, desc.input_a_line_size}, 32'h4);
        checkOutput($sformatf("tile%0d.bLine", idx), {15'd0, desc.input_b_line_size}, 32'h5);
    endtask

    // Walk expected tiles first..first+count-1, optionally stalling one and writing on the last.
    task automatic expectTiles(input int first, input int count, input int stallIdx,
                               input int stallLen, input logic weOnLast);
        for (int t = 0; t < count; t++) begin
            if (t == stallIdx) begin
                desc_ready = 1'b0;
                for (int s = 0; s < stallLen; s++) begin
                    checkTile(first + t);
                    @(negedge clk);
                end
            end
            desc_ready = 1'b1;
            if (weOnLast && (t == count - 1)) output_we = 1'b1;
            checkTile(first + t);
            checkOutput("jobReadyBusy", {31'd0, job_ready}, 32'd0);
            checkOutput("busyIssue", {31'd0, busy}, 32'd1);
            @(negedge clk);
            output_we = 1'b0;
        end
        checkOutput("validDrop", {31'd0, desc.valid}, 32'd0);
    endtask

    task automatic driveWrites(input int count);
        for (int w = 0; w < count; w++) begin
            output_we = 1'b1;
            checkOutput("doneEarly", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        output_we = 1'b0;
    endtask

    task automatic checkDone();
        checkOutput("donePulse", {31'd0, done}, 32'd1);
        checkOutput("readyAtDone", {31'd0, job_ready}, 32'd1);
        checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("doneOnce", {31'd0, done}, 32'd0);
    endtask

    initial begin
        // m=1 n=1 k=16
        expTab[0] = '{a: 15'h0010, b: 17'h00020, c: 15'h0030, n: 12'd16};
        // m=2 n=3 c_line=4 k=32
        expTab[1] = '{a: 15'd0, b: 17'd0, c: 15'd0,  n: 12'd32};
        expTab[2] = '{a: 15'd0, b: 17'd1, c: 15'd1,  n: 12'd32};
        expTab[3] = '{a: 15'd0, b: 17'd2, c: 15'd2,  n: 12'd32};
        expTab[4] = '{a: 15'd1, b: 17'd0, c: 15'd32, n: 12'd32};
        expTab[5] = '{a: 15'd1, b: 17'd1, c: 15'd33, n: 12'd32};
        expTab[6] = '{a: 15'd1, b: 17'd2, c: 15'd34, n: 12'd32};
        // a_base=0x7FFF, c_base=0x7FF0, c_line=2, m=2 n=1 k=8: both wrap on row 2
        expTab[7] = '{a: 15'h7FFF, b: 17'h1FFFF, c: 15'h7FF0, n: 12'd8};
        expTab[8] = '{a: 15'h0000, b: 17'h1FFFF, c: 15'h0000, n: 12'd8};
        // reset-abort job and its successor
        expTab[9] = '{a: 15'd1, b: 17'd2, c: 15'd3, n: 12'd4};

        rst        = 1'b1;
        job_valid  = 1'b0;
        job        = '0;
        desc_ready = 1'b1;
        output_we  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstJobReady", {31'd0, job_ready}, 32'd1);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstDesc", {31'd0, desc == '0}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single tile job");
        applyStimulus(15'h10, 17'h20, 15'h30, 15'd2, 8'd1, 8'd1, 12'd16);
        expectTiles(0, 1, -1, 0, 1'b0);
        driveWrites(8);
        checkDone();

        $display("[TB] 2x3 job, stall on second tile, write on final transfer");
        applyStimulus(15'd0, 17'd0, 15'd0, 15'd4, 8'd2, 8'd3, 12'd32);
        expectTiles(1, 6, 1, 5, 1'b1);
        driveWrites(47);
        checkDone();

        $display("[TB] zero-size job");
        applyStimulus(15'd5, 17'd6, 15'd7, 15'd1, 8'd0, 8'd3, 12'd16);
        checkOutput("zeroNoValid", {31'd0, desc.valid}, 32'd0);
        checkOutput("zeroBusy", {31'd0, busy}, 32'd1);
        checkOutput("zeroDoneEarly", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkDone();

        $display("[TB] address wrap");
        applyStimulus(15'h7FFF, 17'h1FFFF, 15'h7FF0, 15'd2, 8'd2, 8'd1, 12'd8);
        expectTiles(7, 2, -1, 0, 1'b0);
        driveWrites(16);
        checkDone();

        $display("[TB] reset during drain");
        applyStimulus(15'd1, 17'd2, 15'd3, 15'd1, 8'd1, 8'd1, 12'd4);
        expectTiles(9, 1, -1, 0, 1'b0);
        driveWrites(3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortReady", {31'd0, job_ready}, 32'd1);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortValid", {31'd0, desc.valid}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkOutput("abortNoDone", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        applyStimulus(15'd1, 17'd2, 15'd3, 15'd1, 8'd1, 8'd1, 12'd4);
        expectTiles(9, 1, -1, 0, 1'b0);
        driveWrites(8);
        checkDone();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
